jam_param: RTL and testbench

- Parametrised successor to the fixed 8-worker job-assignment search engine.
- Exhaustively enumerates all N! worker-to-job permutations in lexicographic order.
- Fetches each cost from the external cost ROM through the W/J address pair and accumulates the per-permutation total.
- Reports the minimum total cost and the number of permutations achieving it; adds a START/BUSY handshake and a restartable run.

---
 rtl/jam_param.sv | 188 ++++++++++++++++++
 tb/tb_jam_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jam_param.sv
// jam_param: exhaustive job-assignment search over all N! worker-to-job permutations.
// Define JAM_BEST_PERM_EN to add BestPerm (lexicographically first minimum-cost assignment).
module jam_param #(
    parameter int N     = 8,
    parameter int IW    = 3,
    parameter int CW    = 7,
    parameter int SUM_W = 10,
    parameter int MC_W  = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             START,
    output logic             BUSY,
    output logic [IW-1:0]    W,
    output logic [IW-1:0]    J,
    input  logic [CW-1:0]    Cost,
    output logic [MC_W-1:0]  MatchCount,
    output logic [SUM_W-1:0] MinCost,
`ifdef JAM_BEST_PERM_EN
    output logic [N*IW-1:0]  BestPerm,
`endif
    output logic             Valid
);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_LAST, S_UPD, S_DONE} state_e;

    localparam logic [IW-1:0] W_LAST = IW'(N - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     w_q, w_d;
    logic [IW-1:0]     perm_q [N];
    logic [IW-1:0]     perm_d [N];
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [SUM_W-1:0]  min_q, min_d;
    logic [MC_W-1:0]   mc_q, mc_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    logic [IW-1:0]     perm_swp [N];
    logic [IW-1:0]     perm_nxt [N];
    logic              is_last;
    int                piv;
    int                succ;
    logic [SUM_W-1:0]  cost_ext;

    assign cost_ext = SUM_W'(Cost);

    // Lexicographic successor of perm_q; is_last flags the strictly descending permutation.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        is_last = 1'b1;
        piv     = 0;
        for (int i = 0; i < N - 1; i++) begin
            if (perm_q[i] < perm_q[i+1]) begin
                piv     = i;
                is_last = 1'b0;
            end
        end
        succ = piv + 1;
        for (int j = 0; j < N; j++) begin
            if (j > piv && perm_q[j] > perm_q[piv]) succ = j;
        end
        perm_swp       = perm_q;
        perm_swp[piv]  = perm_q[succ];
        perm_swp[succ] = perm_q[piv];
        perm_nxt       = perm_swp;
        for (int k = 0; k < N; k++) begin
            if (k > piv) perm_nxt[k] = perm_swp[N + piv - k];
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_SCAN;
            S_SCAN:  if (w_q == W_LAST) state_d = S_LAST;
            S_LAST:  state_d = S_UPD;
            S_UPD:   state_d = is_last ? S_DONE : S_SCAN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_d     = w_q;
        perm_d  = perm_q;
        sum_d   = sum_q;
        min_d   = min_q;
        mc_d    = mc_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: if (START) begin
                for (int k = 0; k < N; k++) perm_d[k] = IW'(k);
                sum_d   = '0;
                min_d   = '1;
                mc_d    = '0;
                valid_d = 1'b0;
                busy_d  = 1'b1;
                w_d     = '0;
            end
            S_SCAN: begin
                w_d = (w_q == W_LAST) ? '0 : w_q + 1'b1;
                // Cost lags W by one cycle, so the W=0 cycle has nothing to add yet.
                if (w_q != '0) sum_d = sum_q + cost_ext;
            end
            S_LAST: sum_d = sum_q + cost_ext;
            S_UPD: begin
                if (sum_q < min_q) begin
                    min_d = sum_q;
                    mc_d  = MC_W'(1);
                end else if (sum_q == min_q && mc_q != '1) begin
                    mc_d = mc_q + 1'b1;
                end
                if (!is_last) begin
                    perm_d = perm_nxt;
                    sum_d  = '0;
                    w_d    = '0;
                end
            end
            S_DONE: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            // NOTE: perm is a handful of flops, not a RAM, so resetting every entry is cheap and required.
            for (int k = 0; k < N; k++) perm_q[k] <= IW'(k);
            w_q     <= '0;
            sum_q   <= '0;
            min_q   <= '1;
            mc_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            perm_q  <= perm_d;
            w_q     <= w_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            mc_q    <= mc_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

`ifdef JAM_BEST_PERM_EN
    logic [IW-1:0] best_q [N];
    logic [IW-1:0] best_d [N];

    always_comb begin
        best_d = best_q;
        if (state_q == S_IDLE && START) begin
            for (int k = 0; k < N; k++) best_d[k] = IW'(k);
        end else if (state_q == S_UPD && sum_q < min_q) begin
            best_d = perm_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int k = 0; k < N; k++) best_q[k] <= IW'(k);
        end else begin
            best_q <= best_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_best
        assign BestPerm[g*IW +: IW] = best_q[g];
    end
`endif

    assign BUSY       = busy_q;
    assign Valid      = valid_q;
    assign W          = w_q;
    assign J          = perm_q[w_q];
    assign MinCost    = min_q;
    assign MatchCount = mc_q;

endmodule

// File: tb/tb_jam_param.sv
// Self-checking bench for jam_param: three small instances driven by registered cost-ROM models,
// checked against a brute-force assignment model and hand-computed literals.
`timescale 1ns/1ps
module tb_jam_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cost ROM contents selected by mode.
    function automatic int cost_f(input int mode, input int w, input int j);
        case (mode)
            0:       return 1;
            1:       return w * j;
            2:       return w + j;
            3:       return (w == j) ? 0 : 5;
            4:       return 5;
            default: return 0;
        endcase
    endfunction

    // Brute force: walk every n-digit base-n word in lexicographic order, keep only permutations.
    task automatic model_run(input int n, input int mode, input int mcw, input int iw,
                             output longint mn, output longint cnt, output longint best,
                             output longint nperm);
        int d [8];
        int lim, c, total, seen;
        bit ok;
        lim = 1;
        for (int i = 0; i < n; i++) lim *= n;
        mn = 64'h7fff_ffff; cnt = 0; best = 0; nperm = 0;
        for (int code = 0; code < lim; code++) begin
            c = code;
            for (int k = n - 1; k >= 0; k--) begin d[k] = c % n; c = c / n; end
            seen = 0; ok = 1'b1;
            for (int k = 0; k < n; k++) begin
                if (seen[d[k]]) ok = 1'b0;
                seen[d[k]] = 1'b1;
            end
            if (ok) begin
                nperm++;
                total = 0;
                for (int k = 0; k < n; k++) total += cost_f(mode, k, d[k]);
                if (total < mn) begin
                    mn = total; cnt = 1; best = 0;
                    for (int k = 0; k < n; k++) best |= longint'(d[k]) << (k * iw);
                end else if (total == mn) begin
                    cnt++;
                end
            end
        end
        if (cnt > (longint'(1) << mcw) - 1) cnt = (longint'(1) << mcw) - 1;
    endtask

    // ---------------- instance A: N=3 ----------------
    logic       start_a = 1'b0, busy_a, valid_a;
    logic [1:0] w_a, j_a;
    logic [6:0] cost_a = '0;
    logic [15:0] mc_a;
    logic [9:0] min_a;
`ifdef JAM_BEST_PERM_EN
    logic [5:0] best_a;
`endif
    jam_param #(.N(3), .IW(2), .CW(7), .SUM_W(10), .MC_W(16)) dut_a (
        .CLK(clk), .RST_n(rst_n), .START(start_a), .BUSY(busy_a), .W(w_a), .J(j_a),
        .Cost(cost_a), .MatchCount(mc_a), .MinCost(min_a),
`ifdef JAM_BEST_PERM_EN
        .BestPerm(best_a),
`endif
        .Valid(valid_a));

    // ---------------- instance B: N=4, Cost=W*J ----------------
    logic       start_b = 1'b0, busy_b, valid_b;
    logic [1:0] w_b, j_b;
    logic [6:0] cost_b = '0;
    logic [15:0] mc_b;
    logic [9:0] min_b;
`ifdef JAM_BEST_PERM_EN
    logic [7:0] best_b;
`endif
    jam_param #(.N(4), .IW(2), .CW(7), .SUM_W(10), .MC_W(16)) dut_b (
        .CLK(clk), .RST_n(rst_n), .START(start_b), .BUSY(busy_b), .W(w_b), .J(j_b),
        .Cost(cost_b), .MatchCount(mc_b), .MinCost(min_b),
`ifdef JAM_BEST_PERM_EN
        .BestPerm(best_b),
`endif
        .Valid(valid_b));

    // ---------------- instance C: N=4, MC_W=4, Cost=0 (saturation) ----------------
    logic       start_c = 1'b0, busy_c, valid_c;
    logic [1:0] w_c, j_c;
    logic [6:0] cost_c = '0;
    logic [3:0] mc_c;
    logic [9:0] min_c;
`ifdef JAM_BEST_PERM_EN
    logic [7:0] best_c;
`endif
    jam_param #(.N(4), .IW(2), .CW(7), .SUM_W(10), .MC_W(4)) dut_c (
        .CLK(clk), .RST_n(rst_n), .START(start_c), .BUSY(busy_c), .W(w_c), .J(j_c),
        .Cost(cost_c), .MatchCount(mc_c), .MinCost(min_c),
`ifdef JAM_BEST_PERM_EN
        .BestPerm(best_c),
`endif
        .Valid(valid_c));

    // Registered cost ROMs: Cost in cycle c answers the W/J of cycle c-1.
    int mode_a = 0, mode_b = 1, mode_c = 5;
    int pw_a = 0, pj_a = 0, pw_b = 0, pj_b = 0, pw_c = 0, pj_c = 0;
    always @(negedge clk) begin
        cost_a = 7'(cost_f(mode_a, pw_a, pj_a));
        cost_b = 7'(cost_f(mode_b, pw_b, pj_b));
        cost_c = 7'(cost_f(mode_c, pw_c, pj_c));
        pw_a = int'(w_a); pj_a = int'(j_a);
        pw_b = int'(w_b); pj_b = int'(j_b);
        pw_c = int'(w_c); pj_c = int'(j_c);
    end

    // Cycle-level model of instance A and the per-cycle compare process.
    bit     m_busy = 1'b0, m_valid = 1'b0;
    longint m_min = 1023, m_mc = 0, m_best = 6'h24;
    longint e_min, e_mc, e_best, e_nperm;
    longint m_cnt = 0, m_run = 0;
    always begin
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_min = 1023; m_mc = 0; m_best = 6'h24;
        end else if (start_a && !m_busy) begin
            model_run(3, mode_a, 16, 2, e_min, e_mc, e_best, e_nperm);
            m_run  = e_nperm * 5 + 1;
            m_busy = 1'b1; m_valid = 1'b0; m_cnt = 0;
            m_min = 1023; m_mc = 0; m_best = 6'h24;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == m_run) begin
                m_busy = 1'b0; m_valid = 1'b1;
                m_min = e_min; m_mc = e_mc; m_best = e_best;
            end
        end
        #2;
        check("cmp_busy", busy_a, m_busy);
        check("cmp_valid", valid_a, m_valid);
        if (!m_busy) begin
            check("cmp_mincost", min_a, m_min);
            check("cmp_matchcount", mc_a, m_mc);
            check("cmp_w_idle", w_a, 0);
`ifdef JAM_BEST_PERM_EN
            check("cmp_bestperm", best_a, m_best);
`endif
        end
    end

    task automatic pulse(input bit a, input bit b, input bit c);
        @(negedge clk); start_a = a; start_b = b; start_c = c;
        @(negedge clk); start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    // Counts edges from the one after the START edge until Valid is seen, bounded by budget.
    task automatic wait_valid_a(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk); cycles++; #1;
            if (valid_a) return;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int     cyc;
        longint x_min, x_mc, x_best, x_np;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_mincost", min_a, 1023);
        check("rst_matchcount", mc_a, 0);
        check("rst_w", w_a, 0);
        check("rst_j", j_a, 0);
        rst_n = 1'b1;

        // Cost=1 on N=3; W*J on N=4; all-zero with 4-bit MatchCount on N=4
        mode_a = 0; mode_b = 1; mode_c = 5;
        pulse(1, 1, 1);
        wait_valid_a(100, cyc);
        check("t1_valid_latency", cyc, 31);
        check("t1_mincost", min_a, 3);
        check("t1_matchcount", mc_a, 6);
        for (int i = 0; i < 400 && !(valid_b && valid_c); i++) @(negedge clk);
        check("t2_valid_b", valid_b, 1);
        check("t2_mincost_b", min_b, 4);
        check("t2_matchcount_b", mc_b, 1);
        model_run(4, 1, 16, 2, x_min, x_mc, x_best, x_np);
        check("t2_model_min_b", min_b, x_min);
        check("t2_model_mc_b", mc_b, x_mc);
        check("t3_valid_c", valid_c, 1);
        check("t3_mincost_c", min_c, 0);
        check("t3_matchcount_sat_c", mc_c, 15);
`ifdef JAM_BEST_PERM_EN
        check("t2_bestperm_b", best_b, 8'h1B);
        check("t2_model_best_b", best_b, x_best);
        check("t3_bestperm_c", best_c, 8'hE4);
        check("t1_bestperm_a", best_a, 6'h24);
`endif

        // Cost=W+J with a START pulsed mid-run; every total is 6
        mode_a = 2;
        pulse(1, 0, 0);
        repeat (10) @(negedge clk);
        check("t4_busy_mid", busy_a, 1);
        pulse(1, 0, 0);
        wait_valid_a(100, cyc);
        check("t4_valid", valid_a, 1);
        check("t4_mincost", min_a, 6);
        check("t4_matchcount", mc_a, 6);

        // Asynchronous reset during SCAN, then a fresh run
        mode_a = 0;
        pulse(1, 0, 0);
        repeat (6) @(negedge clk);
        check("t5_pre_w", w_a, 1);
        check("t5_pre_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy_a, 0);
        check("t5_rst_valid", valid_a, 0);
        check("t5_rst_mincost", min_a, 1023);
        check("t5_rst_matchcount", mc_a, 0);
        check("t5_rst_w", w_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse(1, 0, 0);
        wait_valid_a(100, cyc);
        check("t5_valid_latency", cyc, 31);
        check("t5_mincost", min_a, 3);
        check("t5_matchcount", mc_a, 6);

        // Diagonal-zero costs, then restart with constant 5
        mode_a = 3;
        pulse(1, 0, 0);
        wait_valid_a(100, cyc);
        check("t6_valid", valid_a, 1);
        check("t6_mincost", min_a, 0);
        check("t6_matchcount", mc_a, 1);
        mode_a = 4;
        pulse(1, 0, 0);
        check("t6_valid_drop", valid_a, 0);
        wait_valid_a(100, cyc);
        check("t6b_valid", valid_a, 1);
        check("t6b_mincost", min_a, 15);
        check("t6b_matchcount", mc_a, 6);
`ifdef JAM_BEST_PERM_EN
        check("t6b_bestperm", best_a, 6'h24);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
